// File: rtl/ost_cfg_access_sequencer.sv
// ost_cfg_access_sequencer
//   Arbitrates the OST timing register block's STC read/write interface between
//   the local sync engine (clock-set and phase/frequency corrections) and the
//   host config path (single-word reads and writes). A clock-set becomes three
//   ordered writes. Host reads wait for a matching response, bounded by a timeout.
//
// Parameters
//   RSP_TIMEOUT  cycles spent in WAIT_RSP before a read is failed (2..255)
//   OST_BASE     base address added to every engine register offset
//
// Ports
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_set_req / o_set_ack         clock-set request (iv_set_time, iv_set_pit)
//   i_cor_req / o_cor_ack         correction request (i_cor_sel, iv_cor_value)
//   i_host_req / o_host_ack       host access (i_host_rd, iv_host_addr,
//                                 i_host_addr_fixed, iv_host_wdata)
//   o_host_werr                   with o_host_ack: host write rejected
//   o_host_rvalid, ov_host_rdata,
//   o_host_rerr                   host read completion, rerr = timed out
//   o_stc_wr, o_stc_rd, ov_stc_addr, ov_stc_wdata, o_stc_addr_fixed
//                                 downstream request, all registered
//   i_stc_wr, iv_stc_rdata, iv_stc_raddr, i_stc_addr_fixed
//                                 read response from the register block
//
// Build option
//   OST_HOST_WRITE_GUARD_EN  when defined, host writes with fixed = 0 to the
//                            engine-owned offsets 2..7 are rejected (werr).
module ost_cfg_access_sequencer #(
    parameter int unsigned RSP_TIMEOUT = 8,
    parameter logic [18:0] OST_BASE    = 19'd0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_set_req,
    input  logic [63:0] iv_set_time,
    input  logic [31:0] iv_set_pit,
    output logic        o_set_ack,
    input  logic        i_cor_req,
    input  logic        i_cor_sel,
    input  logic [31:0] iv_cor_value,
    output logic        o_cor_ack,
    input  logic        i_host_req,
    input  logic        i_host_rd,
    input  logic [18:0] iv_host_addr,
    input  logic        i_host_addr_fixed,
    input  logic [31:0] iv_host_wdata,
    output logic        o_host_ack,
    output logic        o_host_werr,
    output logic        o_host_rvalid,
    output logic [31:0] ov_host_rdata,
    output logic        o_host_rerr,
    output logic        o_stc_wr,
    output logic        o_stc_rd,
    output logic [18:0] ov_stc_addr,
    output logic [31:0] ov_stc_wdata,
    output logic        o_stc_addr_fixed,
    input  logic        i_stc_wr,
    input  logic [31:0] iv_stc_rdata,
    input  logic [18:0] iv_stc_raddr,
    input  logic        i_stc_addr_fixed
);

    localparam logic [18:0] ADDR_TIME_HI = OST_BASE + 19'd2;
    localparam logic [18:0] ADDR_TIME_LO = OST_BASE + 19'd3;
    localparam logic [18:0] ADDR_PIT     = OST_BASE + 19'd4;
    localparam logic [18:0] ADDR_PHASE   = OST_BASE + 19'd6;
    localparam logic [18:0] ADDR_FREQ    = OST_BASE + 19'd7;
    localparam logic [7:0]  CNT_LAST     = 8'(RSP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, SET_HI, SET_LO, SET_PIT, COR_WR, HOST_WR, HOST_RD, WAIT_RSP
    } state_t;

    state_t      state, state_next;
    logic        fair, fair_next;
    logic [7:0]  cnt, cnt_next;
    logic        grant_set, grant_cor, grant_host;
    logic        guard_hit;
    logic        rsp_match;

    // Command fields captured at grant; data only, so no reset needed.
    logic [63:0] set_time;
    logic [31:0] set_pit;
    logic        cor_sel;
    logic [31:0] cor_value;
    logic [18:0] host_addr;
    logic        host_fixed;
    logic [31:0] host_wdata;
    logic        host_blocked;

    logic        stc_wr_next, stc_rd_next, stc_fixed_next;
    logic [18:0] stc_addr_next;
    logic [31:0] stc_wdata_next;
    logic        set_ack_next, cor_ack_next, host_ack_next, host_werr_next;
    logic        rvalid_next, rerr_next;
    logic [31:0] rdata_next;

`ifdef OST_HOST_WRITE_GUARD_EN
    // Non-fixed host writes into the engine-owned window would race the engine.
    assign guard_hit = !i_host_rd && !i_host_addr_fixed &&
                       (iv_host_addr >= ADDR_TIME_HI) && (iv_host_addr <= ADDR_FREQ);
`else
    assign guard_hit = 1'b0;
`endif

    assign rsp_match = i_stc_wr && (iv_stc_raddr == host_addr) &&
                       (i_stc_addr_fixed == host_fixed);

    always_comb begin
        state_next     = state;
        fair_next      = fair;
        cnt_next       = cnt;
        grant_set      = 1'b0;
        grant_cor      = 1'b0;
        grant_host     = 1'b0;
        stc_wr_next    = 1'b0;
        stc_rd_next    = 1'b0;
        stc_fixed_next = 1'b0;
        stc_addr_next  = '0;
        stc_wdata_next = '0;
        set_ack_next   = 1'b0;
        cor_ack_next   = 1'b0;
        host_ack_next  = 1'b0;
        host_werr_next = 1'b0;
        rvalid_next    = 1'b0;
        rerr_next      = 1'b0;
        rdata_next     = '0;

        case (state)
            IDLE: begin
                // A pending fairness credit lets the host jump ahead of the engine once.
                if (fair && i_host_req)  grant_host = 1'b1;
                else if (i_set_req)      grant_set  = 1'b1;
                else if (i_cor_req)      grant_cor  = 1'b1;
                else if (i_host_req)     grant_host = 1'b1;

                if (grant_set) state_next = SET_HI;
                if (grant_cor) state_next = COR_WR;
                if (grant_host) begin
                    fair_next  = 1'b0;
                    state_next = i_host_rd ? HOST_RD : HOST_WR;
                end
            end
            SET_HI: begin
                stc_wr_next    = 1'b1;
                stc_addr_next  = ADDR_TIME_HI;
                stc_wdata_next = set_time[63:32];
                set_ack_next   = 1'b1;
                state_next     = SET_LO;
            end
            SET_LO: begin
                stc_wr_next    = 1'b1;
                stc_addr_next  = ADDR_TIME_LO;
                stc_wdata_next = set_time[31:0];
                state_next     = SET_PIT;
            end
            SET_PIT: begin
                stc_wr_next    = 1'b1;
                stc_addr_next  = ADDR_PIT;
                stc_wdata_next = set_pit;
                fair_next      = 1'b1;
                state_next     = IDLE;
            end
            COR_WR: begin
                stc_wr_next    = 1'b1;
                stc_addr_next  = cor_sel ? ADDR_FREQ : ADDR_PHASE;
                stc_wdata_next = cor_value;
                cor_ack_next   = 1'b1;
                fair_next      = 1'b1;
                state_next     = IDLE;
            end
            HOST_WR: begin
                host_ack_next = 1'b1;
                if (host_blocked) begin
                    host_werr_next = 1'b1;
                end else begin
                    stc_wr_next    = 1'b1;
                    stc_addr_next  = host_addr;
                    stc_wdata_next = host_wdata;
                    stc_fixed_next = host_fixed;
                end
                state_next = IDLE;
            end
            HOST_RD: begin
                stc_rd_next    = 1'b1;
                stc_addr_next  = host_addr;
                stc_fixed_next = host_fixed;
                host_ack_next  = 1'b1;
                cnt_next       = '0;
                state_next     = WAIT_RSP;
            end
            WAIT_RSP: begin
                // A real response wins even on the final timeout cycle.
                if (rsp_match) begin
                    rvalid_next = 1'b1;
                    rdata_next  = iv_stc_rdata;
                    state_next  = IDLE;
                end else if (cnt == CNT_LAST) begin
                    rvalid_next = 1'b1;
                    rerr_next   = 1'b1;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= IDLE;
            fair             <= 1'b0;
            cnt              <= '0;
            o_stc_wr         <= 1'b0;
            o_stc_rd         <= 1'b0;
            ov_stc_addr      <= '0;
            ov_stc_wdata     <= '0;
            o_stc_addr_fixed <= 1'b0;
            o_set_ack        <= 1'b0;
            o_cor_ack        <= 1'b0;
            o_host_ack       <= 1'b0;
            o_host_werr      <= 1'b0;
            o_host_rvalid    <= 1'b0;
            ov_host_rdata    <= '0;
            o_host_rerr      <= 1'b0;
        end else begin
            state            <= state_next;
            fair             <= fair_next;
            cnt              <= cnt_next;
            o_stc_wr         <= stc_wr_next;
            o_stc_rd         <= stc_rd_next;
            ov_stc_addr      <= stc_addr_next;
            ov_stc_wdata     <= stc_wdata_next;
            o_stc_addr_fixed <= stc_fixed_next;
            o_set_ack        <= set_ack_next;
            o_cor_ack        <= cor_ack_next;
            o_host_ack       <= host_ack_next;
            o_host_werr      <= host_werr_next;
            o_host_rvalid    <= rvalid_next;
            ov_host_rdata    <= rdata_next;
            o_host_rerr      <= rerr_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (grant_set) begin
            set_time <= iv_set_time;
            set_pit  <= iv_set_pit;
        end
        if (grant_cor) begin
            cor_sel   <= i_cor_sel;
            cor_value <= iv_cor_value;
        end
        if (grant_host) begin
            host_addr    <= iv_host_addr;
            host_fixed   <= i_host_addr_fixed;
            host_wdata   <= iv_host_wdata;
            host_blocked <= guard_hit;
        end
    end

endmodule

// File: tb/tb_ost_cfg_access_sequencer.sv
module tb_ost_cfg_access_sequencer;

    localparam int          T    = 8;
    localparam logic [18:0] OSTB = 19'd0;
    localparam logic [1:0]  K_SET = 2'd0, K_COR = 2'd1, K_HOST = 2'd2;

    typedef struct packed {
        logic [31:0] cyc;
        logic [18:0] addr;
        logic [31:0] data;
        logic        fixed;
    } wr_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [63:0] t;
        logic [31:0] v;
        logic        sel;
        logic        rd;
        logic [18:0] addr;
        logic        fixed;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        set_req, cor_req, cor_sel, host_req, host_rd, host_fixed;
    logic [63:0] set_time;
    logic [31:0] set_pit, cor_value, host_wdata, stc_rdata;
    logic [18:0] host_addr, stc_raddr;
    logic        stc_rsp, stc_rsp_fixed;
    logic        o_set_ack, o_cor_ack, o_host_ack, o_host_werr, o_host_rvalid, o_host_rerr;
    logic        o_stc_wr, o_stc_rd, o_stc_addr_fixed;
    logic [31:0] ov_host_rdata, ov_stc_wdata;
    logic [18:0] ov_stc_addr;
    logic [91:0] outs;

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  both_cnt = 0;
    int  orphan_werr = 0;
    int  set_ack_n = 0;
    bit  m_fair = 0;
    wr_t wr_log[$], rd_log[$], rv_log[$], exp_q[$];

    ost_cfg_access_sequencer #(.RSP_TIMEOUT(T), .OST_BASE(OSTB)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_set_req(set_req), .iv_set_time(set_time), .iv_set_pit(set_pit), .o_set_ack(o_set_ack),
        .i_cor_req(cor_req), .i_cor_sel(cor_sel), .iv_cor_value(cor_value), .o_cor_ack(o_cor_ack),
        .i_host_req(host_req), .i_host_rd(host_rd), .iv_host_addr(host_addr),
        .i_host_addr_fixed(host_fixed), .iv_host_wdata(host_wdata),
        .o_host_ack(o_host_ack), .o_host_werr(o_host_werr), .o_host_rvalid(o_host_rvalid),
        .ov_host_rdata(ov_host_rdata), .o_host_rerr(o_host_rerr),
        .o_stc_wr(o_stc_wr), .o_stc_rd(o_stc_rd), .ov_stc_addr(ov_stc_addr),
        .ov_stc_wdata(ov_stc_wdata), .o_stc_addr_fixed(o_stc_addr_fixed),
        .i_stc_wr(stc_rsp), .iv_stc_rdata(stc_rdata), .iv_stc_raddr(stc_raddr),
        .i_stc_addr_fixed(stc_rsp_fixed)
    );

    assign outs = {o_set_ack, o_cor_ack, o_host_ack, o_host_werr, o_host_rvalid, ov_host_rdata,
                   o_host_rerr, o_stc_wr, o_stc_rd, ov_stc_addr, ov_stc_wdata, o_stc_addr_fixed};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: every strobe/completion with the posedge index that produced it.
    always @(negedge clk) begin
        if (o_stc_wr)      wr_log.push_back({32'(cyc), ov_stc_addr, ov_stc_wdata, o_stc_addr_fixed});
        if (o_stc_rd)      rd_log.push_back({32'(cyc), ov_stc_addr, 32'd0, o_stc_addr_fixed});
        if (o_host_rvalid) rv_log.push_back({32'(cyc), 19'd0, ov_host_rdata, o_host_rerr});
        if (o_stc_wr && o_stc_rd) both_cnt++;
        if (o_host_werr && !o_host_ack) orphan_werr++;
        if (o_set_ack) set_ack_n++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit guard_blocks(input logic [18:0] a, input logic f);
`ifdef OST_HOST_WRITE_GUARD_EN
        return !f && (a >= OSTB + 19'd2) && (a <= OSTB + 19'd7);
`else
        return 1'b0;
`endif
    endfunction

    function automatic cmd_t mk(input logic [1:0] kind, input logic [63:0] t, input logic [31:0] v,
                                input logic sel, input logic rd, input logic [18:0] a, input logic f);
        mk = {kind, t, v, sel, rd, a, f};
    endfunction

    function automatic int model_pick(input bit s, input bit c, input bit h);
        if (m_fair && h) return 2;
        if (s) return 0;
        if (c) return 1;
        return 2;
    endfunction

    // Grant at edge n: append the writes it must produce, return next arbitration edge.
    task automatic model_issue(input cmd_t c, input int n, output int nxt);
        wr_t e;
        case (c.kind)
            K_SET: begin
                e = {32'(n + 1), OSTB + 19'd2, c.t[63:32], 1'b0}; exp_q.push_back(e);
                e = {32'(n + 2), OSTB + 19'd3, c.t[31:0],  1'b0}; exp_q.push_back(e);
                e = {32'(n + 3), OSTB + 19'd4, c.v,        1'b0}; exp_q.push_back(e);
                m_fair = 1; nxt = n + 4;
            end
            K_COR: begin
                e = {32'(n + 1), c.sel ? OSTB + 19'd7 : OSTB + 19'd6, c.v, 1'b0}; exp_q.push_back(e);
                m_fair = 1; nxt = n + 2;
            end
            default: begin
                if (!guard_blocks(c.addr, c.fixed)) begin
                    e = {32'(n + 1), c.addr, c.v, c.fixed}; exp_q.push_back(e);
                end
                m_fair = 0; nxt = n + 2;
            end
        endcase
    endtask

    // ---------------- requester driver ----------------
    task automatic drive_cmd(input cmd_t c, output int ack_cyc, output bit werr);
        bit got;
        case (c.kind)
            K_SET: begin set_time = c.t; set_pit = c.v; set_req = 1; end
            K_COR: begin cor_sel = c.sel; cor_value = c.v; cor_req = 1; end
            default: begin
                host_rd = c.rd; host_addr = c.addr; host_fixed = c.fixed;
                host_wdata = c.v; host_req = 1;
            end
        endcase
        ack_cyc = -1; werr = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            got = (c.kind == K_SET) ? o_set_ack : (c.kind == K_COR) ? o_cor_ack : o_host_ack;
            if (got) begin ack_cyc = cyc; werr = o_host_werr; break; end
        end
        case (c.kind)
            K_SET:   set_req  = 0;
            K_COR:   cor_req  = 0;
            default: host_req = 0;
        endcase
        if (ack_cyc < 0) begin
            total++; bad++;
            $display("FAIL ack_timeout kind=%0d got=none want=ack within 60 cycles", c.kind);
        end
    endtask

    task automatic clear_logs();
        wr_log.delete(); rd_log.delete(); rv_log.delete(); exp_q.delete(); set_ack_n = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        total++;
        if (outs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", outs); end
        rst = 0; m_fair = 0;
        repeat (3) @(negedge clk);
        total++;
        if (outs !== '0) begin bad++; $display("FAIL idle_outputs got=%h want=0", outs); end
    endtask

    task automatic test_arbitration();
        cmd_t cs, cc, ch;
        bit hs, hc, hh, ps, pc, ph;
        int n, t, t2, k, as_, ac_, ah_, es, ec, eh;
        bit w0, w1, w2;
        for (int it = 0; it < 6; it++) begin
            clear_logs();
            if (it == 0) begin hs = 1; hc = 1; hh = 1; end
            else begin
                {hs, hc, hh} = 3'($urandom_range(1, 7));
            end
            cs = mk(K_SET, {$urandom, $urandom}, $urandom, 1'b0, 1'b0, 19'd0, 1'b0);
            cc = mk(K_COR, 64'd0, $urandom, 1'($urandom_range(0, 1)), 1'b0, 19'd0, 1'b0);
            ch = mk(K_HOST, 64'd0, $urandom, 1'b0, 1'b0, 19'($urandom_range(256, 4095)),
                    1'($urandom_range(0, 1)));
            @(negedge clk);
            n = cyc + 1;
            ps = hs; pc = hc; ph = hh; t = n; es = -1; ec = -1; eh = -1;
            while (ps || pc || ph) begin
                k = model_pick(ps, pc, ph);
                if (k == 0)      begin model_issue(cs, t, t2); es = t + 1; ps = 0; end
                else if (k == 1) begin model_issue(cc, t, t2); ec = t + 1; pc = 0; end
                else             begin model_issue(ch, t, t2); eh = t + 1; ph = 0; end
                t = t2;
            end
            as_ = -1; ac_ = -1; ah_ = -1;
            fork
                begin if (hs) drive_cmd(cs, as_, w0); end
                begin if (hc) drive_cmd(cc, ac_, w1); end
                begin if (hh) drive_cmd(ch, ah_, w2); end
            join
            repeat (4) @(negedge clk);
            total++;
            if (wr_log.size() !== exp_q.size()) begin
                bad++; $display("FAIL arb_wr_count it=%0d got=%0d want=%0d", it, wr_log.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    total++;
                    if (wr_log[i] !== exp_q[i]) begin
                        bad++; $display("FAIL arb_wr[%0d] it=%0d got=%h want=%h", i, it, wr_log[i], exp_q[i]);
                    end
                end
            end
            total++;
            if (as_ !== es || ac_ !== ec || ah_ !== eh) begin
                bad++;
                $display("FAIL arb_ack_cycles it=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d",
                         it, as_, ac_, ah_, es, ec, eh);
            end
        end
    endtask

    task automatic test_engine_cmds();
        cmd_t c;
        int n, nxt, ack;
        bit w;
        clear_logs();
        for (int it = 0; it < 10; it++) begin
            if (it == 0)     c = mk(K_SET, 64'h0000_0001_2345_6789, 32'h100, 1'b0, 1'b0, 19'd0, 1'b0);
            else if (it < 4) c = mk(K_SET, {$urandom, $urandom}, $urandom, 1'b0, 1'b0, 19'd0, 1'b0);
            else             c = mk(K_COR, 64'd0, $urandom, 1'($urandom_range(0, 1)), 1'b0, 19'd0, 1'b0);
            @(negedge clk);
            n = cyc + 1;
            model_issue(c, n, nxt);
            drive_cmd(c, ack, w);
            total++;
            if (ack !== n + 1) begin bad++; $display("FAIL engine_ack it=%0d got=%0d want=%0d", it, ack, n + 1); end
            repeat (4) @(negedge clk);
            if (it == 0) begin
                total++;
                if (set_ack_n !== 1) begin bad++; $display("FAIL set_ack_pulses got=%0d want=1", set_ack_n); end
                total++;
                if (wr_log.size() < 1 || wr_log[0].data !== 32'h0000_0001) begin
                    bad++; $display("FAIL set_first_word got=%0d entries want=data 00000001", wr_log.size());
                end
            end
        end
        total++;
        if (wr_log.size() !== exp_q.size()) begin
            bad++; $display("FAIL engine_wr_count got=%0d want=%0d", wr_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (wr_log[i] !== exp_q[i]) begin
                    bad++; $display("FAIL engine_wr[%0d] got=%h want=%h", i, wr_log[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_host_write();
        cmd_t c;
        int n, nxt, ack;
        bit w;
        logic [18:0] a;
        logic f;
        clear_logs();
        for (int it = 0; it < 8; it++) begin
            case (it)
                0: begin a = 19'd6; f = 1'b0; end
                1: begin a = 19'd6; f = 1'b1; end
                2: begin a = 19'd2; f = 1'b0; end
                3: begin a = 19'd8; f = 1'b0; end
                default: begin a = 19'($urandom_range(0, 15)); f = 1'($urandom_range(0, 1)); end
            endcase
            c = mk(K_HOST, 64'd0, $urandom, 1'b0, 1'b0, a, f);
            @(negedge clk);
            n = cyc + 1;
            model_issue(c, n, nxt);
            drive_cmd(c, ack, w);
            total++;
            if (ack !== n + 1) begin bad++; $display("FAIL hwr_ack it=%0d got=%0d want=%0d", it, ack, n + 1); end
            total++;
            if (w !== guard_blocks(a, f)) begin
                bad++; $display("FAIL hwr_werr it=%0d addr=%0d got=%0d want=%0d", it, a, w, guard_blocks(a, f));
            end
            repeat (3) @(negedge clk);
        end
        total++;
        if (wr_log.size() !== exp_q.size()) begin
            bad++; $display("FAIL hwr_count got=%0d want=%0d", wr_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (wr_log[i] !== exp_q[i]) begin
                    bad++; $display("FAIL hwr[%0d] got=%h want=%h", i, wr_log[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_host_read();
        cmd_t c;
        int n, ack, lat, exp_cyc;
        bit w, match;
        logic [18:0] a, sa;
        logic f, sf;
        logic [31:0] d;
        wr_t e;
        for (int it = 0; it < 7; it++) begin
            clear_logs();
            case (it)
                0: begin a = 19'd0; f = 0; match = 1; lat = 0; d = 32'h0000_3434; sa = 0; sf = 0; end
                1: begin a = 19'd9; f = 0; match = 0; lat = 0; d = 0; sa = 19'd1; sf = 0; end
                2: begin
                    a = 19'($urandom_range(0, 500)); f = 1'($urandom_range(0, 1));
                    match = 0; lat = 0; d = 0; sa = a; sf = ~f;
                end
                default: begin
                    a = 19'($urandom_range(0, 500)); f = 1'($urandom_range(0, 1));
                    match = 1; lat = $urandom_range(0, T - 2); d = $urandom; sa = a ^ 19'd1; sf = f;
                end
            endcase
            c = mk(K_HOST, 64'd0, 32'd0, 1'b0, 1'b1, a, f);
            @(negedge clk);
            n = cyc + 1;
            drive_cmd(c, ack, w);
            m_fair = 0;
            if (match) begin
                for (int k = 0; k < lat; k++) begin
                    stc_rsp = (k == 0); stc_raddr = sa; stc_rsp_fixed = sf; stc_rdata = ~d;
                    @(negedge clk);
                end
                stc_rsp = 1; stc_raddr = a; stc_rsp_fixed = f; stc_rdata = d;
                @(negedge clk);
                stc_rsp = 0;
                exp_cyc = n + 2 + lat;
            end else begin
                stc_rsp = 1; stc_raddr = sa; stc_rsp_fixed = sf; stc_rdata = $urandom;
                @(negedge clk);
                stc_rsp = 0;
                exp_cyc = n + 1 + T;
            end
            repeat (T + 4) @(negedge clk);
            total++;
            if (ack !== n + 1) begin bad++; $display("FAIL hrd_ack it=%0d got=%0d want=%0d", it, ack, n + 1); end
            e = {32'(n + 1), a, 32'd0, f};
            total++;
            if (rd_log.size() !== 1 || rd_log[0] !== e) begin
                bad++; $display("FAIL hrd_strobe it=%0d got=%0d entries want=1 at %h", it, rd_log.size(), e);
            end
            e = {32'(exp_cyc), 19'd0, d, ~match};
            total++;
            if (rv_log.size() !== 1 || rv_log[0] !== e) begin
                bad++;
                $display("FAIL hrd_rvalid it=%0d got=%0d entries first=%h want=%h", it, rv_log.size(),
                         (rv_log.size() > 0) ? rv_log[0] : '0, e);
            end
            total++;
            if (wr_log.size() !== 0) begin bad++; $display("FAIL hrd_no_write it=%0d got=%0d want=0", it, wr_log.size()); end
        end
    endtask

    task automatic test_reset_mid_set();
        cmd_t c;
        int n, nxt, ack;
        bit w;
        wr_t first;
        clear_logs();
        c = mk(K_SET, {$urandom, $urandom}, $urandom, 1'b0, 1'b0, 19'd0, 1'b0);
        @(negedge clk);
        n = cyc + 1;
        model_issue(c, n, nxt);
        first = exp_q[0];
        drive_cmd(c, ack, w);
        rst = 1;
        @(negedge clk);
        total++;
        if (outs !== '0) begin bad++; $display("FAIL midreset_outputs got=%h want=0", outs); end
        rst = 0; m_fair = 0;
        repeat (6) @(negedge clk);
        total++;
        if (wr_log.size() !== 1 || wr_log[0] !== first) begin
            bad++; $display("FAIL midreset_writes got=%0d entries want=1 (%h)", wr_log.size(), first);
        end
        clear_logs();
        c = mk(K_SET, {$urandom, $urandom}, $urandom, 1'b0, 1'b0, 19'd0, 1'b0);
        @(negedge clk);
        n = cyc + 1;
        model_issue(c, n, nxt);
        drive_cmd(c, ack, w);
        repeat (5) @(negedge clk);
        total++;
        if (wr_log.size() !== exp_q.size()) begin
            bad++; $display("FAIL reissue_count got=%0d want=%0d", wr_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (wr_log[i] !== exp_q[i]) begin
                    bad++; $display("FAIL reissue_wr[%0d] got=%h want=%h", i, wr_log[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_strobe_rules();
        total++;
        if (both_cnt !== 0) begin bad++; $display("FAIL wr_rd_overlap got=%0d want=0", both_cnt); end
        total++;
        if (orphan_werr !== 0) begin bad++; $display("FAIL werr_without_ack got=%0d want=0", orphan_werr); end
    endtask

    initial begin
        rst = 1; set_req = 0; cor_req = 0; host_req = 0; cor_sel = 0; host_rd = 0; host_fixed = 0;
        set_time = '0; set_pit = '0; cor_value = '0; host_wdata = '0; host_addr = '0;
        stc_rsp = 0; stc_rdata = '0; stc_raddr = '0; stc_rsp_fixed = 0;
        test_reset();
        test_arbitration();
        test_engine_cmds();
        test_host_write();
        test_host_read();
        test_reset_mid_set();
        test_strobe_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
